// File: rtl/debug_step_monitor.sv
// Step/dump controller for the RISC debug board: button debounce, CPU clock-enable
// generation, dump address counter, memory mux and display register. Optional macro: STEP_COUNT_EN.
module debug_step_monitor #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 16,
    parameter int DISP_W     = 16,
    parameter int DEB_CYCLES = 50000,
    parameter int AUTO_DIV   = 25000000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              btn_step,
    input  logic              btn_dump,
    input  logic [1:0]        mode,
    input  logic              dump_en,
    input  logic [1:0]        disp_sel,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_mw_en,
    input  logic [7:0]        cpu_status,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              cpu_ce,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [15:0]       step_count,
    output logic [DISP_W-1:0] disp_data
);

    localparam int CW = $clog2(DEB_CYCLES);
    localparam int DW = $clog2(AUTO_DIV);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYCLES - 1);
    localparam logic [DW-1:0] AUTO_LAST = DW'(AUTO_DIV - 1);

    typedef enum logic [1:0] {
        MODE_HALT = 2'b00,
        MODE_STEP = 2'b01,
        MODE_AUTO = 2'b10,
        MODE_RUN  = 2'b11
    } mode_e;

    mode_e mode_w;
    assign mode_w = mode_e'(mode);

    // Index 0 is the step button, index 1 the dump button.
    logic [1:0]    btn_raw;
    logic [1:0]    sync1_q, sync2_q, deb_q, pulse_q;
    logic [CW-1:0] cnt_q [2];

    assign btn_raw = {btn_dump, btn_step};

    // A level is accepted after DEB_CYCLES consecutive samples that differ from
    // the current debounced level; any agreeing sample restarts the count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            pulse_q <= '0;
            for (int b = 0; b < 2; b++) cnt_q[b] <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            for (int b = 0; b < 2; b++) begin
                pulse_q[b] <= 1'b0;
                if (sync2_q[b] == deb_q[b]) begin
                    cnt_q[b] <= '0;
                end else if (cnt_q[b] == DEB_LAST) begin
                    cnt_q[b]   <= '0;
                    deb_q[b]   <= sync2_q[b];
                    pulse_q[b] <= sync2_q[b];
                end else begin
                    cnt_q[b] <= cnt_q[b] + CW'(1);
                end
            end
        end
    end

    logic              cpu_ce_q, cpu_ce_d;
    logic [DW-1:0]     div_q, div_d;
    logic              auto_tick;
    logic [ADDR_W-1:0] dump_addr_q, dump_addr_d;
    logic [DISP_W-1:0] disp_q, disp_d;

    // Divider sits at zero outside AUTO, so entering AUTO always starts a fresh period.
    always_comb begin
        div_d     = div_q;
        auto_tick = 1'b0;
        if (mode_w != MODE_AUTO) begin
            div_d = '0;
        end else if (!dump_en) begin
            if (div_q == AUTO_LAST) begin
                div_d     = '0;
                auto_tick = 1'b1;
            end else begin
                div_d = div_q + DW'(1);
            end
        end
    end

    always_comb begin
        cpu_ce_d = 1'b0;
        if (!dump_en) begin
            case (mode_w)
                MODE_HALT: cpu_ce_d = 1'b0;
                MODE_STEP: cpu_ce_d = pulse_q[0];
                MODE_AUTO: cpu_ce_d = auto_tick;
                MODE_RUN:  cpu_ce_d = 1'b1;
                default:   cpu_ce_d = 1'b0;
            endcase
        end
    end

    always_comb begin
        dump_addr_d = dump_addr_q;
        if (dump_en && pulse_q[1]) dump_addr_d = dump_addr_q + ADDR_W'(1);
    end

    always_comb begin
        disp_d = '0;
        case (disp_sel)
            2'b00:   disp_d = DISP_W'(mem_addr);
            2'b01:   disp_d = DISP_W'(mem_rdata);
            2'b10:   disp_d = DISP_W'(cpu_addr);
`ifdef STEP_COUNT_EN
            2'b11:   disp_d = DISP_W'(step_count);
`else
            2'b11:   disp_d = DISP_W'(cpu_status);
`endif
            default: disp_d = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cpu_ce_q    <= 1'b0;
            div_q       <= '0;
            dump_addr_q <= '0;
            disp_q      <= '0;
        end else begin
            cpu_ce_q    <= cpu_ce_d;
            div_q       <= div_d;
            dump_addr_q <= dump_addr_d;
            disp_q      <= disp_d;
        end
    end

`ifdef STEP_COUNT_EN
    logic [15:0] step_count_q, step_count_d;
    logic        unused_status;

    assign unused_status = ^cpu_status;
    assign step_count_d  = cpu_ce_q ? step_count_q + 16'd1 : step_count_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) step_count_q <= '0;
        else        step_count_q <= step_count_d;
    end

    assign step_count = step_count_q;
`else
    assign step_count = '0;
`endif

    assign cpu_ce    = cpu_ce_q;
    assign dump_addr = dump_addr_q;
    assign disp_data = disp_q;
    assign mem_addr  = dump_en ? dump_addr_q : cpu_addr;
    // Dump mode can never write memory.
    assign mem_we    = cpu_mw_en & cpu_ce_q & ~dump_en;

endmodule

// File: tb/tb_debug_step_monitor.sv
// Directed bench for debug_step_monitor with small debounce/divider parameters.
module tb_debug_step_monitor;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 16;
    localparam int DISP_W = 16;
    localparam int DEB    = 4;
    localparam int ADIV   = 8;
`ifdef STEP_COUNT_EN
    localparam bit SC_EN = 1'b1;
`else
    localparam bit SC_EN = 1'b0;
`endif

    logic              clock, reset;
    logic              btn_step, btn_dump;
    logic [1:0]        mode, disp_sel;
    logic              dump_en, cpu_mw_en;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_status;
    logic [DATA_W-1:0] mem_rdata;
    logic              cpu_ce, mem_we;
    logic [ADDR_W-1:0] mem_addr, dump_addr;
    logic [15:0]       step_count;
    logic [DISP_W-1:0] disp_data;

    int n_checks = 0;
    int n_fail   = 0;

    debug_step_monitor #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DISP_W(DISP_W),
        .DEB_CYCLES(DEB), .AUTO_DIV(ADIV)
    ) dut (
        .clock(clock), .reset(reset),
        .btn_step(btn_step), .btn_dump(btn_dump),
        .mode(mode), .dump_en(dump_en), .disp_sel(disp_sel),
        .cpu_addr(cpu_addr), .cpu_mw_en(cpu_mw_en), .cpu_status(cpu_status),
        .mem_rdata(mem_rdata),
        .cpu_ce(cpu_ce), .mem_addr(mem_addr), .mem_we(mem_we),
        .dump_addr(dump_addr), .step_count(step_count), .disp_data(disp_data)
    );

    // Clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Driver and checker tasks
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic count_ce(input int n, output int highs);
        highs = 0;
        repeat (n) begin
            @(posedge clock);
            #1;
            if (cpu_ce) highs++;
        end
    endtask

    task automatic press_dump();
        btn_dump = 1'b1;
        cycles(DEB + 4);
        btn_dump = 1'b0;
        cycles(DEB + 4);
    endtask

    int highs, highs2, bad, k;
    logic [ADDR_W-1:0] exp_a;

    initial begin
        reset = 1'b0; btn_step = 1'b0; btn_dump = 1'b0; mode = 2'b00;
        dump_en = 1'b0; disp_sel = 2'b00; cpu_addr = '0; cpu_mw_en = 1'b0;
        cpu_status = 8'h00; mem_rdata = '0;

        // Reset state
        cycles(3);
        check("rst_cpu_ce", cpu_ce, 0);
        check("rst_dump_addr", dump_addr, 0);
        check("rst_step_count", step_count, 0);
        check("rst_disp_data", disp_data, 0);
        check("rst_mem_we", mem_we, 0);
        reset = 1'b1;
        cycles(2);

        // Test 1: bouncy step press in STEP mode gives one pulse
        mode = 2'b01;
        btn_step = 1'b1; cycles(1);
        btn_step = 1'b0; cycles(1);
        btn_step = 1'b1; cycles(1);
        btn_step = 1'b0; cycles(1);
        btn_step = 1'b1;
        count_ce(10, highs);
        btn_step = 1'b0;
        count_ce(20, highs2);
        check("step_one_pulse", highs + highs2, 1);
        check("step_count_1", step_count, SC_EN ? 32'd1 : 32'd0);

        // Test 2: dump press ignored while dump_en=0, then 17 presses wrap the counter
        mode = 2'b00;
        press_dump();
        check("dump_ignored", dump_addr, 0);
        mode = 2'b11; dump_en = 1'b1; cpu_mw_en = 1'b1; cpu_addr = 4'h9;
        for (int i = 1; i <= 17; i++) begin
            press_dump();
            exp_a = ADDR_W'(i);
            check("dump_addr", dump_addr, exp_a);
            check("dump_mem_addr", mem_addr, exp_a);
            check("dump_mem_we", mem_we, 0);
            check("dump_cpu_ce", cpu_ce, 0);
        end

        // Test 3: AUTO ticks every 8 cycles, dump_en freezes it
        mode = 2'b10; dump_en = 1'b0; cpu_mw_en = 1'b0;
        highs = 0; bad = 0;
        for (k = 1; k <= 80; k++) begin
            @(posedge clock);
            #1;
            if (cpu_ce) begin
                highs++;
                if (k % 8 != 0) bad++;
            end
        end
        check("auto_pulses", highs, 10);
        check("auto_spacing", bad, 0);
        dump_en = 1'b1;
        count_ce(16, highs);
        check("auto_dump_ce", highs, 0);
        check("step_count_11", step_count, SC_EN ? 32'd11 : 32'd0);
        mode = 2'b00; dump_en = 1'b0;
        cycles(2);

        // Test 5: display select, registered one cycle later
        cpu_addr = 4'h3; mem_rdata = 16'hBEEF; cpu_status = 8'h5A; disp_sel = 2'b00;
        cycles(1);
        check("disp_00", disp_data, 16'h0003);
        disp_sel = 2'b01;
        #1;
        check("disp_01_hold", disp_data, 16'h0003);
        cycles(1);
        check("disp_01", disp_data, 16'hBEEF);
        disp_sel = 2'b10; cpu_addr = 4'hC;
        #1;
        check("disp_10_hold", disp_data, 16'hBEEF);
        cycles(1);
        check("disp_10", disp_data, 16'h000C);
        disp_sel = 2'b11;
        cycles(1);
        check("disp_11", disp_data, SC_EN ? 32'd11 : 32'h005A);

        // Test 4: dump_en in RUN blocks writes at once and the CPU next cycle
        mode = 2'b11; dump_en = 1'b0; cpu_mw_en = 1'b1; cpu_addr = 4'h6;
        cycles(2);
        check("run_ce", cpu_ce, 1);
        check("run_we", mem_we, 1);
        dump_en = 1'b1;
        #1;
        check("dumpon_we_now", mem_we, 0);
        check("dumpon_ce_still", cpu_ce, 1);
        check("dumpon_mem_addr", mem_addr, 1);
        cycles(1);
        check("dumpon_ce_next", cpu_ce, 0);
        dump_en = 1'b0;
        #1;
        check("dumpoff_ce_now", cpu_ce, 0);
        cycles(1);
        check("dumpoff_ce_next", cpu_ce, 1);
        check("dumpoff_we", mem_we, 1);

        // Test 6: asynchronous reset in RUN with dump_addr=5
        mode = 2'b00; dump_en = 1'b1; cpu_mw_en = 1'b0;
        repeat (4) press_dump();
        check("pre_rst_dump", dump_addr, 5);
        mode = 2'b11; dump_en = 1'b0; cpu_addr = '0; disp_sel = 2'b00;
        cycles(3);
        check("pre_rst_ce", cpu_ce, 1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_cpu_ce", cpu_ce, 0);
        check("arst_dump_addr", dump_addr, 0);
        check("arst_mem_addr", mem_addr, 0);
        check("arst_mem_we", mem_we, 0);
        check("arst_step_count", step_count, 0);
        check("arst_disp", disp_data, 0);
        #1;
        reset = 1'b1;
        #1;
        check("release_ce_low", cpu_ce, 0);
        cycles(1);
        check("release_ce_edge", cpu_ce, 1);

        // Final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
